// File: rtl/seq_divider_32.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH steps per operation.
// Holds the last quotient/remainder until the next result; busy stalls the pipeline during CALC.
module seq_divider_32 #(
    parameter int unsigned WIDTH  = 32,
    parameter logic [2:0]  DIV_OP = 3'b010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             execute,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   q_work_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   quotient_q, remainder_q;
    logic               dbz_q;

    logic               start, accept, last_step;
    logic [WIDTH+1:0]   shifted, trial;
    logic               trial_ok;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   q_next;

    assign start     = execute && (alu_ctrl == DIV_OP);
    assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
    assign last_step = (state_q == StCalc) && (count_q == CNT_W'(WIDTH - 1));

    // One restoring step; the top bit of trial is the borrow that signals a negative result.
    always_comb begin
        shifted  = {rem_q, q_work_q[WIDTH-1]};
        trial    = shifted - {2'b00, divisor_q};
        trial_ok = ~trial[WIDTH+1];
        rem_next = trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
        q_next   = {q_work_q[WIDTH-2:0], trial_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (divisor == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = (divisor == '0) ? StDone : StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StCalc:  busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            q_work_q    <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept) begin
            divisor_q <= divisor;
            q_work_q  <= dividend;
            rem_q     <= '0;
            count_q   <= '0;
            // Zero divisor bypasses CALC and publishes the result at the accept edge.
            if (divisor == '0) begin
                quotient_q  <= '1;
                remainder_q <= dividend;
                dbz_q       <= 1'b1;
            end
        end else if (state_q == StCalc) begin
            rem_q    <= rem_next;
            q_work_q <= q_next;
            count_q  <= count_q + 1'b1;
            if (last_step) begin
                quotient_q  <= q_next;
                remainder_q <= rem_next[WIDTH-1:0];
                dbz_q       <= 1'b0;
            end
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Scoreboard bench for seq_divider_32: stimulus pushes expected {dbz, q, r}; a monitor pops on done.
module tb_seq_divider_32;

    localparam int unsigned W   = 32;
    localparam logic [2:0]  DIV = 3'b010;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         execute = 1'b0;
    logic [2:0]   alu_ctrl = 3'b000;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    logic [64:0]  sb[$];
    int           checks = 0;
    int           failures = 0;
    int           n_done = 0;
    int           n_acc = 0;
    vec_t         vecs[9];

    always #5 clk = ~clk;

    seq_divider_32 #(.WIDTH(W), .DIV_OP(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .execute     (execute),
        .alu_ctrl    (alu_ctrl),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {1'b1, 32'hFFFF_FFFF, a};
        return {1'b0, a / b, a % b};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got %h expected no result",
                         {div_by_zero, quotient, remainder});
            end else begin
                e = sb.pop_front();
                check("result", {div_by_zero, quotient, remainder}, e);
            end
        end
    end

    // Call at a negedge; start is seen by the next rising edge, returns one negedge later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [64:0] exp);
        execute  = 1'b1;
        alu_ctrl = DIV;
        dividend = a;
        divisor  = b;
        sb.push_back(exp);
        n_acc++;
        @(negedge clk);
        execute = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (!done && n < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    initial begin
        int          bc;
        logic [W-1:0] ra, rb;

        vecs[0] = '{32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[1] = '{32'h5,         32'h9,         32'h0,         32'h5,         1'b0};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[3] = '{32'h1234,      32'h0,         32'hFFFF_FFFF, 32'h1234,      1'b1};
        vecs[4] = '{32'hDEAD_BEEF, 32'h10,        32'h0DEA_DBEE, 32'hF,         1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0};
        vecs[6] = '{32'h0,         32'h5,         32'h0,         32'h0,         1'b0};
        vecs[7] = '{32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[8] = '{32'hFFFF_FFFF, 32'h2,         32'h7FFF_FFFF, 32'h1,         1'b0};

        repeat (2) @(negedge clk);
        check("reset_qr", {1'b0, quotient, remainder}, 65'd0);
        check("reset_flags", {62'd0, busy, done, div_by_zero}, 65'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'd100, 32'd7, {1'b0, 32'd14, 32'd2});
        wait_done(bc);
        check("basic_busy_cycles", 65'(bc), 65'd32);

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b, {vecs[i].z, vecs[i].q, vecs[i].r});
            wait_done(bc);
            check("vec_busy_cycles", 65'(bc), vecs[i].z ? 65'd0 : 65'd32);
        end

        // New operands during CALC must not disturb the running operation.
        @(negedge clk);
        issue(32'd1000, 32'd3, {1'b0, 32'd333, 32'd1});
        repeat (5) @(negedge clk);
        execute  = 1'b1;
        alu_ctrl = DIV;
        dividend = 32'd50;
        divisor  = 32'd5;
        repeat (2) @(negedge clk);
        execute = 1'b0;
        wait_done(bc);

        @(negedge clk);
        execute  = 1'b1;
        alu_ctrl = 3'b001;
        dividend = 32'd9;
        divisor  = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nondiv_busy_done", {63'd0, busy, done}, 65'd0);
            check("nondiv_hold", {div_by_zero, quotient, remainder}, {1'b0, 32'd333, 32'd1});
        end
        execute = 1'b0;

        // Back-to-back: second start is presented during the DONE cycle.
        @(negedge clk);
        issue(32'd81, 32'd9, {1'b0, 32'd9, 32'd0});
        wait_done(bc);
        issue(32'h1234_5678, 32'h1000, {1'b0, 32'h0001_2345, 32'h0000_0678});
        check("b2b_busy", {64'd0, busy}, 65'd1);
        wait_done(bc);

        @(negedge clk);
        issue(32'hDEAD_BEEF, 32'h13, model(32'hDEAD_BEEF, 32'h13));
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_qr", {1'b0, quotient, remainder}, 65'd0);
        check("abort_flags", {62'd0, busy, done, div_by_zero}, 65'd0);
        sb.delete();
        n_acc--;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'd7, 32'd7, {1'b0, 32'd1, 32'd0});
        wait_done(bc);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = (i % 16 == 0) ? '0 : $urandom;
                1:       rb = $urandom & 32'hFF;
                2:       rb = $urandom >> $urandom_range(31, 0);
                default: rb = $urandom;
            endcase
            if (rb == '0 && (i % 16 != 0)) rb = 32'd1;
            @(negedge clk);
            issue(ra, rb, model(ra, rb));
            wait_done(bc);
        end

        repeat (3) @(negedge clk);
        check("done_count", 65'(n_done), 65'(n_acc));
        check("scoreboard_empty", 65'(sb.size()), 65'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
